// File: rtl/sram_frame_arbiter.sv
// Double-buffered 1M x16 async SRAM arbiter: VGA reads from the display frame, draw-engine writes to the other.
// Optional grant statistics are compiled in when SRAM_ARB_STATS_EN is defined.
module sram_frame_arbiter #(
   parameter logic [19:0] FRAME_WORDS   = 20'h4B000,
   parameter int          MAX_RD_STREAK = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        rd_req,
   input  logic [19:0] rd_addr,
   output logic        rd_ack,
   output logic        rd_valid,
   output logic [15:0] rd_data,
   input  logic        wr_req,
   input  logic [19:0] wr_addr,
   input  logic [15:0] wr_data,
   input  logic [1:0]  wr_be,
   output logic        wr_ack,
   input  logic        swap_req,
   output logic        swap_done,
   output logic        disp_frame,
   output logic [19:0] SRAM_ADDR,
   input  logic [15:0] SRAM_DQ_in,
   output logic [15:0] SRAM_DQ_out,
   output logic        SRAM_DQ_oe,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
`ifdef SRAM_ARB_STATS_EN
   output logic [31:0] stat_rd_cnt,
   output logic [31:0] stat_wr_cnt,
`endif
   output logic [2:0]  dbg_state
);

   // Handshake: rd_req/wr_req are levels held by the requester until the matching
   // 1-cycle ack; the request fields are consumed on the grant edge, so the ack is
   // seen the cycle after. rd_valid and swap_done are 1-cycle pulses with no back-pressure.

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD1    = 3'd1,
      RD2    = 3'd2,
      RD_CAP = 3'd3,
      WR1    = 3'd4,
      WR2    = 3'd5,
      WR3    = 3'd6
   } state_t;

   localparam int SW = (MAX_RD_STREAK < 1) ? 1 : $clog2(MAX_RD_STREAK + 1);
   localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_RD_STREAK);

   state_t        state;
   logic          swap_pend;
   logic [SW-1:0] streak;
   logic [15:0]   cap_q;
   logic          oor_q;
   logic [1:0]    be_q;

   logic [19:0]   disp_base;
   logic [19:0]   draw_base;
   logic [19:0]   rd_sum;
   logic [19:0]   wr_sum;
   logic          rd_oor;
   logic          wr_oor;
   logic          wr_grant;
   logic [SW-1:0] streak_next;

   assign disp_base   = disp_frame ? FRAME_WORDS : 20'h00000;
   assign draw_base   = disp_frame ? 20'h00000 : FRAME_WORDS;
   assign rd_sum      = disp_base + rd_addr;
   assign wr_sum      = draw_base + wr_addr;
   assign rd_oor      = (rd_addr >= FRAME_WORDS);
   assign wr_oor      = (wr_addr >= FRAME_WORDS);
   // Reads win unless the write has already waited out a full streak of reads.
   assign wr_grant    = wr_req && (!rd_req || (streak == STREAK_MAX));
   assign streak_next = !wr_req ? '0 : ((streak == STREAK_MAX) ? streak : streak + 1'b1);
   assign dbg_state   = state;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= IDLE;
         swap_pend   <= 1'b0;
         streak      <= '0;
         cap_q       <= 16'h0000;
         oor_q       <= 1'b0;
         be_q        <= 2'b00;
         rd_ack      <= 1'b0;
         rd_valid    <= 1'b0;
         rd_data     <= 16'h0000;
         wr_ack      <= 1'b0;
         swap_done   <= 1'b0;
         disp_frame  <= 1'b0;
         SRAM_ADDR   <= 20'h00000;
         SRAM_DQ_out <= 16'h0000;
         SRAM_DQ_oe  <= 1'b0;
         SRAM_CE_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_WE_N   <= 1'b1;
      end else begin
         rd_ack    <= 1'b0;
         rd_valid  <= 1'b0;
         wr_ack    <= 1'b0;
         swap_done <= 1'b0;
         if (swap_req) swap_pend <= 1'b1;

         case (state)
            IDLE: begin
               if (swap_pend) begin
                  // A vsync landing on the apply cycle stays pending for a second swap.
                  disp_frame <= ~disp_frame;
                  swap_done  <= 1'b1;
                  swap_pend  <= swap_req;
               end else if (wr_grant) begin
                  state       <= WR1;
                  wr_ack      <= 1'b1;
                  streak      <= '0;
                  oor_q       <= wr_oor;
                  be_q        <= wr_be;
                  SRAM_ADDR   <= wr_sum;
                  SRAM_DQ_out <= wr_data;
                  SRAM_DQ_oe  <= ~wr_oor;
                  SRAM_CE_N   <= wr_oor;
                  SRAM_OE_N   <= 1'b1;
                  SRAM_WE_N   <= 1'b1;
               end else if (rd_req) begin
                  state     <= RD1;
                  rd_ack    <= 1'b1;
                  streak    <= streak_next;
                  oor_q     <= rd_oor;
                  SRAM_ADDR <= rd_sum;
                  SRAM_CE_N <= rd_oor;
                  SRAM_OE_N <= rd_oor;
                  SRAM_UB_N <= rd_oor;
                  SRAM_LB_N <= rd_oor;
               end
            end
            RD1: state <= RD2;
            RD2: begin
               state     <= RD_CAP;
               cap_q     <= oor_q ? 16'h0000 : SRAM_DQ_in;
               SRAM_CE_N <= 1'b1;
               SRAM_OE_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
            end
            RD_CAP: begin
               // Staged one cycle so rd_data only changes together with rd_valid.
               state    <= IDLE;
               rd_data  <= cap_q;
               rd_valid <= 1'b1;
            end
            WR1: begin
               state <= WR2;
               if (!oor_q) begin
                  SRAM_WE_N <= 1'b0;
                  SRAM_UB_N <= ~be_q[1];
                  SRAM_LB_N <= ~be_q[0];
               end
            end
            WR2: begin
               state     <= WR3;
               SRAM_WE_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
            end
            WR3: begin
               state      <= IDLE;
               SRAM_CE_N  <= 1'b1;
               SRAM_DQ_oe <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SRAM_ARB_STATS_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         stat_rd_cnt <= 32'd0;
         stat_wr_cnt <= 32'd0;
      end else if (state == IDLE) begin
         if (swap_pend) begin
            stat_rd_cnt <= 32'd0;
            stat_wr_cnt <= 32'd0;
         end else if (wr_grant) begin
            stat_wr_cnt <= stat_wr_cnt + 32'd1;
         end else if (rd_req) begin
            stat_rd_cnt <= stat_rd_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
